// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the helpers that
// derive frame totals and counter widths from a timing set.
package vga_timing_pkg;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int vga_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one screen axis: advances on i_inc, wraps from MAX-1 to 0,
// and exposes its next value so callers can register decodes in step with it.
module vga_axis_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_count;

    assign o_tc    = (r_count == LAST);
    assign o_count = r_count;

    always_comb begin
        o_next = r_count;
        if (i_inc) begin
            o_next = o_tc ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator: prescaled pixel tick, x/y counters and
// registered sync/blank decodes. Define VGA_SYNC_FRAME_COUNT_EN to add frame_cnt.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pixel_tick,
    output logic [vga_cw(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] pixel_x,
    output logic [vga_cw(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] pixel_y,
    output logic video_on,
    output logic hsync,
    output logic vsync,
    output logic line_start,
    output logic frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int CW_H    = vga_cw(H_TOTAL);
    localparam int CW_V    = vga_cw(V_TOTAL);
    localparam int PW      = vga_cw(CLK_DIV);

    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW_H-1:0] H_VIS    = CW_H'(H_ACTIVE);
    localparam logic [CW_H-1:0] HS_FIRST = CW_H'(H_ACTIVE + H_FP);
    localparam logic [CW_H-1:0] HS_LAST  = CW_H'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW_V-1:0] V_VIS    = CW_V'(V_ACTIVE);
    localparam logic [CW_V-1:0] VS_FIRST = CW_V'(V_ACTIVE + V_FP);
    localparam logic [CW_V-1:0] VS_LAST  = CW_V'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic            HS_ON    = HS_POL[0];
    localparam logic            VS_ON    = VS_POL[0];

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
        H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 ||
        HS_POL < 0 || HS_POL > 1 || VS_POL < 0 || VS_POL > 1) begin : g_bad_params
        $error("vga_sync_gen: illegal timing parameters");
    end

    logic [PW-1:0]   r_pre;
    logic            r_tick;
    logic            r_line;
    logic            r_frame;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_vid;
    logic            w_tick;
    logic            w_h_tc;
    logic            w_v_tc;
    logic [CW_H-1:0] w_x_next;
    logic [CW_V-1:0] w_y_next;

    assign w_tick = enable && (r_pre == PRE_LAST);

    vga_axis_counter #(.MAX(H_TOTAL), .W(CW_H)) u_h_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_tick),
        .o_count (pixel_x),
        .o_next  (w_x_next),
        .o_tc    (w_h_tc)
    );

    vga_axis_counter #(.MAX(V_TOTAL), .W(CW_V)) u_v_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_tick && w_h_tc),
        .o_count (pixel_y),
        .o_next  (w_y_next),
        .o_tc    (w_v_tc)
    );

    // Decodes use the counters' next values so they land in the same clock as the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_hsync <= ~HS_ON;
            r_vsync <= ~VS_ON;
            r_vid   <= 1'b1;
        end else begin
            if (enable) begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
            end
            r_tick  <= w_tick;
            r_line  <= w_tick && w_h_tc;
            r_frame <= w_tick && w_h_tc && w_v_tc;
            r_hsync <= (w_x_next >= HS_FIRST && w_x_next <= HS_LAST) ? HS_ON : ~HS_ON;
            r_vsync <= (w_y_next >= VS_FIRST && w_y_next <= VS_LAST) ? VS_ON : ~VS_ON;
            r_vid   <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
        end
    end

    assign pixel_tick  = r_tick;
    assign line_start  = r_line;
    assign frame_start = r_frame;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_vid;

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] r_fcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcnt <= '0;
        end else if (w_tick && w_h_tc && w_v_tc) begin
            r_fcnt <= r_fcnt + 16'd1;
        end
    end

    assign frame_cnt = r_fcnt;
`endif

endmodule
